// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 core and its host-side controller:
// controller state encoding, digest size and default memory map.
package sha256_pkg;

    // Number of 32-bit words in a SHA-256 digest (h0..h7).
    localparam int unsigned DIGEST_WORDS = 8;

    // Default message length and memory map of the shared message memory.
    localparam int unsigned DEFAULT_NUM_OF_WORDS = 20;
    localparam logic [15:0] DEFAULT_MSG_ADDR     = 16'h0000;
    localparam logic [15:0] DEFAULT_OUT_ADDR     = 16'h0100;

    // Host controller states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_KICK    = 3'd3,
        ST_WAIT    = 3'd4,
        ST_RD_ADDR = 3'd5,
        ST_RD_DATA = 3'd6,
        ST_DRAIN   = 3'd7
    } host_state_e;

    // Word address arithmetic; sums wrap modulo 2^16.
    function automatic logic [15:0] word_addr(input logic [15:0] base,
                                              input logic [15:0] offset);
        return base + offset;
    endfunction

endpackage

// File: rtl/sha256_host_ctrl.sv
// Host-side controller for the SHA-256 core: writes a streamed message into
// the shared message memory, starts the core, waits for it to finish, then
// reads the eight digest words back and streams them out.
module sha256_host_ctrl
    import sha256_pkg::*;
#(
    parameter int unsigned NUM_OF_WORDS = DEFAULT_NUM_OF_WORDS,
    parameter logic [15:0] MSG_ADDR     = DEFAULT_MSG_ADDR,
    parameter logic [15:0] OUT_ADDR     = DEFAULT_OUT_ADDR
) (
    input  logic        clk,
    input  logic        reset_n,
    // message input stream
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    // digest output stream
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    // core control
    output logic        sha_start,
    input  logic        sha_done,
    output logic [15:0] message_addr,
    output logic [15:0] output_addr,
    // shared memory port
    output logic        host_mem_sel,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    // status
    output logic        busy
);

    localparam logic [7:0] LAST_IDX = 8'(NUM_OF_WORDS - 1);
    localparam logic [2:0] LAST_K   = 3'(DIGEST_WORDS - 1);

    host_state_e state;
    host_state_e state_nxt;

    logic [7:0] idx;
    logic [2:0] k;
    logic       in_hs;
    logic       out_hs;
    logic       rd_launch;
    logic [2:0] rd_k;

    assign message_addr = MSG_ADDR;
    assign output_addr  = OUT_ADDR;
    assign mem_clk      = clk;

    assign in_hs  = (state == ST_LOAD) && in_valid;
    assign out_hs = (state == ST_DRAIN) && out_valid && out_ready;

    // A digest read is launched when the core finishes, and after every
    // accepted digest word except the last one. rd_k is the word it fetches.
    assign rd_launch = ((state == ST_WAIT) && sha_done) ||
                       (out_hs && (k != LAST_K));
    assign rd_k      = (state == ST_DRAIN) ? (k + 3'd1) : k;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_nxt    = state;
        in_ready     = 1'b0;
        sha_start    = 1'b0;
        host_mem_sel = 1'b0;
        busy         = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                // Only wakes up here; the word is taken in LOAD.
                if (in_valid) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready     = 1'b1;
                host_mem_sel = 1'b1;
                if (in_hs && (idx == LAST_IDX)) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Final registered write is on the port this cycle.
                host_mem_sel = 1'b1;
                state_nxt    = ST_KICK;
            end
            ST_KICK: begin
                // Core owns the memory; wait for it to leave idle.
                sha_start = 1'b1;
                if (!sha_done) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (sha_done) begin
                    state_nxt = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                host_mem_sel = 1'b1;
                state_nxt    = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                host_mem_sel = 1'b1;
                state_nxt    = ST_DRAIN;
            end
            ST_DRAIN: begin
                host_mem_sel = 1'b1;
                if (out_hs) begin
                    state_nxt = (k == LAST_K) ? ST_IDLE : ST_RD_ADDR;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Message word index; restarts from zero for every run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx <= 8'd0;
        end else if (state == ST_IDLE) begin
            idx <= 8'd0;
        end else if (in_hs) begin
            idx <= (idx == LAST_IDX) ? 8'd0 : (idx + 8'd1);
        end
    end

    // Digest word index; 3-bit, wraps back to zero after h7.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k <= 3'd0;
        end else if (state == ST_IDLE) begin
            k <= 3'd0;
        end else if (out_hs) begin
            k <= k + 3'd1;
        end
    end

    // Registered memory port: one write per accepted word, one cycle later,
    // and the digest read address set up on entry to RD_ADDR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_we         <= 1'b0;
            mem_addr       <= 16'h0000;
            mem_write_data <= 32'h0000_0000;
        end else begin
            mem_we <= in_hs;
            if (in_hs) begin
                mem_addr       <= word_addr(MSG_ADDR, {8'd0, idx});
                mem_write_data <= in_data;
            end else if (rd_launch) begin
                mem_addr <= word_addr(OUT_ADDR, {13'd0, rd_k});
            end
        end
    end

    // Digest output register; data and last flag hold while the sink stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= 32'h0000_0000;
            out_last  <= 1'b0;
        end else if (state == ST_RD_DATA) begin
            out_valid <= 1'b1;
            out_data  <= mem_read_data;
            out_last  <= (k == LAST_K);
        end else if (out_hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sha256_host_ctrl.sv
// Testbench for sha256_host_ctrl: core stub, synchronous memory model and a
// scoreboard that derives expected writes/digest words from the message and
// memory contents of each run.
module tb_sha256_host_ctrl;
    import sha256_pkg::*;

    localparam int          N     = 20;
    localparam logic [15:0] MSG_A = 16'h0000;
    localparam logic [15:0] OUT_A = 16'h0100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic        sha_start;
    logic        sha_done = 1'b1;
    logic [15:0] message_addr;
    logic [15:0] output_addr;
    logic        host_mem_sel;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data = 32'h0;
    logic        busy;

    sha256_host_ctrl #(
        .NUM_OF_WORDS(N),
        .MSG_ADDR    (MSG_A),
        .OUT_ADDR    (OUT_A)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .sha_start     (sha_start),
        .sha_done      (sha_done),
        .message_addr  (message_addr),
        .output_addr   (output_addr),
        .host_mem_sel  (host_mem_sel),
        .mem_clk       (mem_clk),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_write_data(mem_write_data),
        .mem_read_data (mem_read_data),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Run configuration shared with the stub, sink and memory model.
    int          stall_pct = 0;
    int          drop_dly = 3;
    int          busy_len = 50;
    logic [31:0] dig_mem [8];
    logic [31:0] msg [N];

    // Synchronous memory: digest region returns the preloaded words.
    always @(posedge clk) begin
        logic [15:0] off;
        off = mem_addr - OUT_A;
        if (host_mem_sel && !mem_we && (off < 16'd8)) mem_read_data <= dig_mem[off[2:0]];
        else mem_read_data <= 32'h0;
    end

    // Core stub: drops sha_done drop_dly cycles after start, raises it busy_len later.
    int stub_cnt = -1;
    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            sha_done = 1'b1;
            stub_cnt = -1;
        end else if (stub_cnt < 0) begin
            if (sha_start) begin
                stub_cnt = 0;
                if (drop_dly == 0) sha_done = 1'b0;
            end
        end else begin
            stub_cnt++;
            if (stub_cnt == drop_dly) sha_done = 1'b0;
            if (stub_cnt == drop_dly + busy_len) begin
                sha_done = 1'b1;
                stub_cnt = -1;
            end
        end
    end

    // Digest sink with random backpressure.
    always @(posedge clk) begin
        #1;
        out_ready = (int'($urandom_range(99)) >= stall_pct);
    end

    // Scoreboard: expected writes follow accepted words by one cycle at
    // MSG_A+n; digest words must equal memory contents in order.
    typedef struct { int cyc; logic [15:0] addr; logic [31:0] data; } wr_t;
    wr_t         exp_wr[$];
    int          word_no = 0, out_cnt = 0, start_len = 0, wr_seen = 0;
    int          done_cyc = 0, last_hs_cyc = 0, last_out_cyc = 0;
    bit          rd_pending = 0, stalled = 0;
    logic [31:0] held_data = 32'h0;
    logic        held_last = 1'b0;
    logic        prev_start = 1'b0, prev_done = 1'b1, prev_busy = 1'b0;

    always @(negedge clk) begin
        wr_t w;
        if (!reset_n) begin
            exp_wr.delete();
            word_no = 0; out_cnt = 0; start_len = 0; wr_seen = 0;
            rd_pending = 0; stalled = 0;
        end else begin
            if (busy && !prev_busy) begin
                out_cnt = 0; start_len = 0; word_no = 0; wr_seen = 0;
            end
            if (mem_we) begin
                check("we_with_sel", host_mem_sel, 1);
                check("write_expected", exp_wr.size() > 0, 1);
                if (exp_wr.size() > 0) begin
                    w = exp_wr.pop_front();
                    check("wr_cycle", cyc, w.cyc);
                    check("wr_addr", mem_addr, w.addr);
                    check("wr_data", mem_write_data, w.data);
                end
                wr_seen++;
            end
            if (in_valid && in_ready) begin
                w.cyc  = cyc + 1;
                w.addr = MSG_A + 16'(word_no);
                w.data = in_data;
                exp_wr.push_back(w);
                word_no++;
                last_hs_cyc = cyc;
            end
            if (sha_start) begin
                if (!prev_start) check("start_delay", cyc - last_hs_cyc, 2);
                start_len++;
            end
            if (sha_done && !prev_done) begin
                done_cyc = cyc;
                rd_pending = 1;
            end
            if (rd_pending && host_mem_sel) begin
                check("first_rd_delay", cyc - done_cyc, 1);
                check("first_rd_addr", mem_addr, OUT_A);
                check("first_rd_we", mem_we, 0);
                rd_pending = 0;
            end
            if (stalled) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, held_data);
                check("stall_last", out_last, held_last);
            end
            stalled   = out_valid && !out_ready;
            held_data = out_data;
            held_last = out_last;
            if (out_valid && out_ready) begin
                check("digest_in_range", out_cnt < 8, 1);
                if (out_cnt < 8) begin
                    check("digest_data", out_data, dig_mem[out_cnt]);
                    check("digest_last", out_last, out_cnt == 7);
                end
                out_cnt++;
                last_out_cyc = cyc;
            end
        end
        prev_start = sha_start;
        prev_done  = sha_done;
        prev_busy  = busy;
    end

    task automatic feed(input int count, input int gap);
        int i = 0;
        int guard = 0;
        bit hs;
        while (i < count && guard < 5000) begin
            in_valid = (int'($urandom_range(99)) >= gap);
            in_data  = msg[i];
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (hs) i++;
            guard++;
        end
        in_valid = 1'b0;
        check("feed_count", i, count);
    endtask

    task automatic wait_idle();
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(out_cnt == 8 && !busy) && guard < 3000);
        check("run_no_timeout", guard < 3000, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_sha_start"}, sha_start, 0);
        check({tag, "_host_mem_sel"}, host_mem_sel, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_write_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_mem_clk"}, mem_clk, clk);
        check({tag, "_message_addr"}, message_addr, MSG_A);
        check({tag, "_output_addr"}, output_addr, OUT_A);
    endtask

    typedef struct {
        int gap_pct;
        int stall_pct;
        int drop;
        int busy;
        bit directed;
        int exp_start_len;
        int exp_rd_cyc;
    } scen_t;

    task automatic run(input scen_t s);
        for (int k = 0; k < 8; k++) dig_mem[k] = s.directed ? (32'hD000_0000 + 32'(k)) : $urandom;
        for (int n = 0; n < N; n++) msg[n] = s.directed ? (32'h0123_4567 + 32'(n)) : $urandom;
        stall_pct = s.stall_pct;
        drop_dly  = s.drop;
        busy_len  = s.busy;
        feed(N, s.gap_pct);
        wait_idle();
        check("writes_seen", wr_seen, N);
        check("writes_all_done", exp_wr.size(), 0);
        check("digest_count", out_cnt, 8);
        check("start_len", start_len, s.exp_start_len);
        if (s.exp_rd_cyc >= 0) check("readout_cycles", last_out_cyc - done_cyc, s.exp_rd_cyc);
        check("idle_in_ready", in_ready, 0);
    endtask

    scen_t tbl [6];

    initial begin
        //          gap stall drop busy dir start rd
        tbl[0] = '{  0,   0,   3,  50, 1'b1, 4,  24};
        tbl[1] = '{ 30,  40,   3,  10, 1'b0, 4,  -1};
        tbl[2] = '{  0,   0,   0,   5, 1'b0, 1,  24};
        tbl[3] = '{ 50,  60,   1,  20, 1'b0, 2,  -1};
        tbl[4] = '{ 10,  20,   2,   8, 1'b0, 3,  -1};
        tbl[5] = '{  0,   0,   5,   1, 1'b0, 6,  24};

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_busy", busy, 0);

        for (int t = 0; t < 6; t++) run(tbl[t]);

        // Reset pulse after 7 accepted words, then a clean full run.
        for (int n = 0; n < N; n++) msg[n] = 32'hA5A5_0000 + 32'(n);
        stall_pct = 0;
        drop_dly  = 3;
        busy_len  = 10;
        feed(7, 0);
        check("midrst_busy_before", busy, 1);
        reset_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        run(tbl[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
